// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11/DHT22 sensor emulator and the reader:
// state encoding, frame constants, default timing in 50 MHz cycles.
package dht_pkg;

    localparam int unsigned CNT_W      = 20;
    localparam int unsigned FRAME_BITS = 40;
    localparam int unsigned GUARD_LEN  = 8;

    localparam logic [CNT_W-1:0] DEF_START_MIN_LOW = 20'd800000;
    localparam logic [CNT_W-1:0] DEF_RESP_WAIT     = 20'd2100;
    localparam logic [CNT_W-1:0] DEF_RESP_LOW      = 20'd4000;
    localparam logic [CNT_W-1:0] DEF_RESP_HIGH     = 20'd4000;
    localparam logic [CNT_W-1:0] DEF_BIT_LOW       = 20'd2500;
    localparam logic [CNT_W-1:0] DEF_HIGH_ZERO     = 20'd1400;
    localparam logic [CNT_W-1:0] DEF_HIGH_ONE      = 20'd3500;
    localparam logic [CNT_W-1:0] DEF_END_LOW       = 20'd2500;
    localparam logic [CNT_W-1:0] DEF_SHORT_MIN     = 20'd16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RESP_WAIT = 3'd1;
    localparam logic [2:0] ST_RESP_LOW  = 3'd2;
    localparam logic [2:0] ST_RESP_HIGH = 3'd3;
    localparam logic [2:0] ST_BIT_LOW   = 3'd4;
    localparam logic [2:0] ST_BIT_HIGH  = 3'd5;
    localparam logic [2:0] ST_END_LOW   = 3'd6;
    localparam logic [2:0] ST_GUARD     = 3'd7;

    function automatic logic drives_low(input logic [2:0] st);
        return (st == ST_RESP_LOW) || (st == ST_BIT_LOW) || (st == ST_END_LOW);
    endfunction

    // Checksum is the 8-bit wrapped sum of the four data bytes.
    function automatic logic [7:0] frame_checksum(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] c, input logic [7:0] d);
        logic [9:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[7:0];
    endfunction

endpackage

// File: rtl/dht_in_sync.sv
// Two-flop synchronizer for the open-drain sensor line; resets to the idle
// (released/high) level so reset never looks like a host start.
module dht_in_sync (
    input  logic clk_50M,
    input  logic reset,
    input  logic i_line,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/dht_sensor_emu.sv
// DHT11/DHT22 sensor-side emulator: answers a host start pulse with the
// response and a 40-bit frame. Define DHT_EMU_ERR_INJECT_EN to enable err_inject.
module dht_sensor_emu
    import dht_pkg::*;
#(
    parameter logic [CNT_W-1:0] START_MIN_LOW = DEF_START_MIN_LOW,
    parameter logic [CNT_W-1:0] RESP_WAIT     = DEF_RESP_WAIT,
    parameter logic [CNT_W-1:0] RESP_LOW      = DEF_RESP_LOW,
    parameter logic [CNT_W-1:0] RESP_HIGH     = DEF_RESP_HIGH,
    parameter logic [CNT_W-1:0] BIT_LOW       = DEF_BIT_LOW,
    parameter logic [CNT_W-1:0] HIGH_ZERO     = DEF_HIGH_ZERO,
    parameter logic [CNT_W-1:0] HIGH_ONE      = DEF_HIGH_ONE,
    parameter logic [CNT_W-1:0] END_LOW       = DEF_END_LOW,
    parameter logic [CNT_W-1:0] SHORT_MIN     = DEF_SHORT_MIN
) (
    input  logic       clk_50M,
    input  logic       reset,
    inout  wire        sensor,
    input  logic [7:0] RH_integral,
    input  logic [7:0] RH_decimal,
    input  logic [7:0] T_integral,
    input  logic [7:0] T_decimal,
    input  logic       err_inject,
    output logic       busy,
    output logic       frame_done,
    output logic       short_start
);

    localparam logic [5:0]       LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] GUARD_W  = CNT_W'(GUARD_LEN);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] r_low_cnt;
    logic [CNT_W-1:0] w_phase_len;
    logic [5:0]       r_bit_idx;
    logic [39:0]      r_frame;
    logic             r_drive_low;
    logic             r_busy;
    logic             r_done;
    logic             r_short;
    logic             w_sync;
    logic             w_release;
    logic             w_accept;
    logic             w_reject;
    logic             w_phase_end;
    logic             w_last_bit;
    logic [7:0]       w_cks;

    dht_in_sync u_sync (
        .clk_50M (clk_50M),
        .reset   (reset),
        .i_line  (sensor),
        .o_sync  (w_sync)
    );

`ifdef DHT_EMU_ERR_INJECT_EN
    assign w_cks = frame_checksum(RH_integral, RH_decimal, T_integral, T_decimal)
                   ^ {7'd0, err_inject};
`else
    logic w_unused_err;
    assign w_unused_err = err_inject;
    assign w_cks = frame_checksum(RH_integral, RH_decimal, T_integral, T_decimal);
`endif

    // A nonzero low count with the line back high is the host's rising edge.
    assign w_release  = w_sync && (r_low_cnt != '0);
    assign w_accept   = (r_state == ST_IDLE) && w_release && (r_low_cnt >= START_MIN_LOW);
    assign w_reject   = (r_state == ST_IDLE) && w_release && (r_low_cnt >= SHORT_MIN)
                        && (r_low_cnt < START_MIN_LOW);
    assign w_last_bit = (r_bit_idx == LAST_BIT);

    always_comb begin
        w_phase_len = '0;
        case (r_state)
            ST_RESP_WAIT: w_phase_len = RESP_WAIT;
            ST_RESP_LOW:  w_phase_len = RESP_LOW;
            ST_RESP_HIGH: w_phase_len = RESP_HIGH;
            ST_BIT_LOW:   w_phase_len = BIT_LOW;
            ST_BIT_HIGH:  w_phase_len = r_frame[39] ? HIGH_ONE : HIGH_ZERO;
            ST_END_LOW:   w_phase_len = END_LOW;
            ST_GUARD:     w_phase_len = GUARD_W;
            default:      w_phase_len = '0;
        endcase
    end

    assign w_phase_end = (r_state != ST_IDLE) && (r_tcnt == w_phase_len - 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept)    w_state_nxt = ST_RESP_WAIT;
            ST_RESP_WAIT: if (w_phase_end) w_state_nxt = ST_RESP_LOW;
            ST_RESP_LOW:  if (w_phase_end) w_state_nxt = ST_RESP_HIGH;
            ST_RESP_HIGH: if (w_phase_end) w_state_nxt = ST_BIT_LOW;
            ST_BIT_LOW:   if (w_phase_end) w_state_nxt = ST_BIT_HIGH;
            ST_BIT_HIGH:  if (w_phase_end) w_state_nxt = w_last_bit ? ST_END_LOW : ST_BIT_LOW;
            ST_END_LOW:   if (w_phase_end) w_state_nxt = ST_GUARD;
            ST_GUARD:     if (w_phase_end) w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_tcnt      <= '0;
            r_low_cnt   <= '0;
            r_bit_idx   <= '0;
            r_drive_low <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_short     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drive_low <= drives_low(w_state_nxt);
            r_done      <= (r_state == ST_END_LOW) && w_phase_end;
            r_short     <= w_reject;

            if (w_accept || w_phase_end)
                r_tcnt <= '0;
            else if (r_state != ST_IDLE)
                r_tcnt <= r_tcnt + 1'b1;

            // The line is only watched in IDLE; the count saturates at all-ones.
            if ((r_state == ST_IDLE) && !w_sync) begin
                if (r_low_cnt != '1)
                    r_low_cnt <= r_low_cnt + 1'b1;
            end else begin
                r_low_cnt <= '0;
            end

            if (w_accept)
                r_busy <= 1'b1;
            else if ((r_state == ST_END_LOW) && w_phase_end)
                r_busy <= 1'b0;

            if (w_accept)
                r_bit_idx <= '0;
            else if ((r_state == ST_BIT_HIGH) && w_phase_end && !w_last_bit)
                r_bit_idx <= r_bit_idx + 1'b1;
        end
    end

    // Frame payload is latched at acceptance and shifted MSB first, one bit per BIT_HIGH.
    always_ff @(posedge clk_50M) begin
        if (w_accept)
            r_frame <= {RH_integral, RH_decimal, T_integral, T_decimal, w_cks};
        else if ((r_state == ST_BIT_HIGH) && w_phase_end)
            r_frame <= {r_frame[38:0], 1'b0};
    end

    assign sensor      = r_drive_low ? 1'b0 : 1'bz;
    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign short_start = r_short;

endmodule

// File: tb/tb_dht_sensor_emu.sv
// Bench for dht_sensor_emu with shortened timing; the line is decoded into
// run lengths and compared with a run list built from the protocol rules.
module tb_dht_sensor_emu;

    localparam int P_SMIN  = 200;
    localparam int P_RW    = 21;
    localparam int P_RL    = 40;
    localparam int P_RH    = 40;
    localparam int P_BL    = 25;
    localparam int P_HZ    = 14;
    localparam int P_HO    = 35;
    localparam int P_EL    = 25;
    localparam int P_SHORT = 16;
    localparam int GUARD   = 8;
    localparam int TAIL    = GUARD + 6;
    // Release is first sampled one edge after the host lets go, then 2 sync stages.
    localparam int LAT     = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] rh_i = 8'd0, rh_d = 8'd0, t_i = 8'd0, t_d = 8'd0;
    logic       err_inj = 1'b0;
    wire        sensor;
    wire        busy, frame_done, short_start;

    pullup (sensor);
    assign sensor = host_low ? 1'b0 : 1'bz;

    dht_sensor_emu #(
        .START_MIN_LOW (20'(P_SMIN)),
        .RESP_WAIT     (20'(P_RW)),
        .RESP_LOW      (20'(P_RL)),
        .RESP_HIGH     (20'(P_RH)),
        .BIT_LOW       (20'(P_BL)),
        .HIGH_ZERO     (20'(P_HZ)),
        .HIGH_ONE      (20'(P_HO)),
        .END_LOW       (20'(P_EL)),
        .SHORT_MIN     (20'(P_SHORT))
    ) dut (
        .clk_50M     (clk),
        .reset       (rst_n),
        .sensor      (sensor),
        .RH_integral (rh_i),
        .RH_decimal  (rh_d),
        .T_integral  (t_i),
        .T_decimal   (t_d),
        .err_inject  (err_inj),
        .busy        (busy),
        .frame_done  (frame_done),
        .short_start (short_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cap_line[$], cap_busy[$], cap_done[$], cap_short[$];
    int exp_val[$], exp_len[$], act_val[$], act_len[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int line_now();
        return (sensor === 1'b1) ? 1 : 0;
    endfunction

    task automatic host_start(input int len);
        @(posedge clk); #1 host_low = 1'b1;
        repeat (len) @(posedge clk);
        #1 host_low = 1'b0;
    endtask

    // Sample i is taken at the falling edge after the i-th rising edge following release.
    task automatic capture(input int n, input bit scramble);
        cap_line.delete(); cap_busy.delete(); cap_done.delete(); cap_short.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_line.push_back(line_now());
            cap_busy.push_back(int'(busy));
            cap_done.push_back(int'(frame_done));
            cap_short.push_back(int'(short_start));
            if (scramble && i >= LAT) begin
                rh_i = 8'($urandom); rh_d = 8'($urandom);
                t_i  = 8'($urandom); t_d  = 8'($urandom);
                err_inj = 1'($urandom);
            end
        end
    endtask

    task automatic encode_runs();
        act_val.delete(); act_len.delete();
        foreach (cap_line[i]) begin
            if (act_val.size() != 0 && act_val[$] == cap_line[i])
                act_len[$] = act_len[$] + 1;
            else begin
                act_val.push_back(cap_line[i]);
                act_len.push_back(1);
            end
        end
    endtask

    function automatic int sum_q(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic frame_test(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input bit inj,
                              input int low_len, input bit scramble);
        int cks, t_end, errs, n, first_busy, done_at, n_done, n_short;
        logic [39:0] frame;
        logic [7:0]  got [5];
        logic [7:0]  want [5];
        rh_i = a; rh_d = b; t_i = c; t_d = d; err_inj = inj;
        cks = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
`ifdef DHT_EMU_ERR_INJECT_EN
        if (inj) cks = cks ^ 1;
`endif
        frame = {a, b, c, d, 8'(cks)};
        want[0] = a; want[1] = b; want[2] = c; want[3] = d; want[4] = 8'(cks);
        exp_val = '{1, 0, 1}; exp_len = '{LAT + P_RW, P_RL, P_RH};
        for (int k = 0; k < 40; k++) begin
            exp_val.push_back(0); exp_len.push_back(P_BL);
            exp_val.push_back(1); exp_len.push_back(frame[39-k] ? P_HO : P_HZ);
        end
        exp_val.push_back(0); exp_len.push_back(P_EL);
        t_end = sum_q(exp_len);
        exp_val.push_back(1); exp_len.push_back(TAIL);

        host_start(low_len);
        capture(t_end + TAIL, scramble);
        encode_runs();

        check({name, ":runs"}, act_len.size(), exp_len.size());
        errs = 0;
        n = (act_len.size() < exp_len.size()) ? act_len.size() : exp_len.size();
        for (int i = 0; i < n; i++)
            if (act_val[i] != exp_val[i] || act_len[i] != exp_len[i]) errs++;
        check({name, ":timing_errs"}, errs, 0);
        check({name, ":resp_delay"}, (act_len.size() > 0) ? act_len[0] : -1, LAT + P_RW);

        for (int j = 0; j < 5; j++) begin
            got[j] = 8'd0;
            for (int k = 0; k < 8; k++) begin
                int idx = 4 + 2 * (8 * j + k);
                got[j] = {got[j][6:0], (idx < act_len.size()) && (act_len[idx] > (P_HZ + P_HO) / 2)};
            end
            check($sformatf("%s:byte%0d", name, j), int'(got[j]), int'(want[j]));
        end

        first_busy = -1; done_at = -1; n_done = 0; n_short = 0;
        foreach (cap_busy[i]) begin
            if (cap_busy[i] == 1 && first_busy < 0) first_busy = i;
            if (cap_done[i] == 1) begin n_done++; done_at = i; end
            n_short += cap_short[i];
        end
        check({name, ":busy_start"}, first_busy, LAT);
        check({name, ":busy_cycles"}, sum_q(cap_busy), t_end - LAT);
        check({name, ":done_pulses"}, n_done, 1);
        check({name, ":done_at"}, done_at, t_end);
        check({name, ":short_pulses"}, n_short, 0);
    endtask

    task automatic short_test(input string name, input int len, input int exp_short);
        int n_low;
        host_start(len);
        capture(40, 1'b0);
        n_low = 0;
        foreach (cap_line[i]) n_low += 1 - cap_line[i];
        check({name, ":short_pulses"}, sum_q(cap_short), exp_short);
        check({name, ":line_driven"}, n_low, 0);
        check({name, ":busy_cycles"}, sum_q(cap_busy), 0);
    endtask

    task automatic midframe_reset();
        int k_cyc, n_done, n_busy;
        logic [39:0] frame;
        rh_i = 8'hA5; rh_d = 8'h3C; t_i = 8'h0F; t_d = 8'hF0; err_inj = 1'b0;
        frame = {rh_i, rh_d, t_i, t_d, 8'((int'(rh_i) + int'(rh_d) + int'(t_i) + int'(t_d)) % 256)};
        k_cyc = LAT + P_RW + P_RL + P_RH;
        for (int k = 0; k < 20; k++) k_cyc += P_BL + (frame[39-k] ? P_HO : P_HZ);
        k_cyc += 5;
        host_start(P_SMIN + 50);
        repeat (k_cyc) @(negedge clk);
        check("midreset:pre_line", line_now(), 0);
        check("midreset:pre_busy", int'(busy), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset:line", line_now(), 1);
        check("midreset:busy", int'(busy), 0);
        n_done = int'(frame_done);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_done += int'(frame_done);
            n_busy += int'(busy);
        end
        check("midreset:done_pulses", n_done, 0);
        check("midreset:busy_after", n_busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset:busy", int'(busy), 0);
        check("reset:frame_done", int'(frame_done), 0);
        check("reset:short_start", int'(short_start), 0);
        check("reset:line", line_now(), 1);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        frame_test("nominal", 8'd55, 8'd0, 8'd24, 8'd0, 1'b0, P_SMIN + 100, 1'b0);
        frame_test("wrap", 8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0, P_SMIN + 10, 1'b0);

        short_test("short_mid", 100, 1);
        short_test("short_below_min", P_SMIN - 1, 1);
        short_test("short_at_floor", P_SHORT, 1);
        short_test("glitch", P_SHORT - 1, 0);

        frame_test("accept_at_min", 8'd60, 8'd5, 8'd30, 8'd2, 1'b0, P_SMIN, 1'b0);
        frame_test("err_inject", 8'd60, 8'd5, 8'd30, 8'd2, 1'b1, P_SMIN + 20, 1'b0);

        for (int r = 0; r < 4; r++)
            frame_test($sformatf("rand%0d", r), 8'($urandom), 8'($urandom), 8'($urandom),
                       8'($urandom), 1'($urandom), P_SMIN + int'($urandom_range(0, 300)), 1'b1);

        midframe_reset();
        frame_test("after_reset", 8'd60, 8'd5, 8'd30, 8'd2, 1'b0, P_SMIN + 40, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dht_sensor_emu.md
Name: dht_sensor_emu

Overview:
Emulates the sensor end of the DHT11/DHT22 single-wire protocol on the shared open-drain `sensor` line. It detects the host start pulse, sends the 80 µs low/high response, then transmits a 40-bit frame of supplied humidity and temperature values plus a computed checksum. It is used for loopback bring-up of the existing DHT reader on the FPGA and as a synthesizable bench model.

Parameters:
- START_MIN_LOW, 800000: minimum host low, in clk_50M cycles, accepted as a start (16 ms).
- RESP_WAIT, 2100: cycles from host release to the start of the response low.
- RESP_LOW, 4000: response low length.
- RESP_HIGH, 4000: response high length.
- BIT_LOW, 2500: per-bit low preamble length.
- HIGH_ZERO, 1400: high length for a '0' bit.
- HIGH_ONE, 3500: high length for a '1' bit.
- END_LOW, 2500: trailing low after bit 39.
- SHORT_MIN, 16: minimum low length that flags a rejected start.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset.
- sensor  inout  1  open-drain line: driven 0 or released to 'z'; an external pull-up is required.
- RH_integral  in  8  humidity byte 0.
- RH_decimal  in  8  humidity byte 1.
- T_integral  in  8  temperature byte 2.
- T_decimal  in  8  temperature byte 3.
- err_inject  in  1  checksum corruption request (see Optional Feature).
- busy  out  1  high from start acceptance until the frame finishes.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- short_start  out  1  one-cycle pulse when a start low is rejected.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-low.
- Reset (`reset`=0 at a clock edge):
  - Line released from the next edge.
  - State returns to IDLE and all counters clear.
  - busy, frame_done and short_start go to 0.
  - Applies mid-frame too: the frame is aborted with no done pulse.
- Line input: sampled through a 2-FF synchronizer (sync_in); 'z' or 1 reads as high. All edge detection uses sync_in, so detection latency is 2 cycles.
- Counters:
  - One 20-bit timing counter, plus a 20-bit low counter saturating at 2^20-1.
  - Every parameter must be below 2^20.
  - Each phase lasts exactly its parameter value in cycles, counted from the state-entry edge.
- IDLE (line released):
  - While sync_in=0, low_cnt increments.
  - When sync_in returns high with low_cnt>=START_MIN_LOW: latch the four data bytes; compute checksum = (RH_integral + RH_decimal + T_integral + T_decimal) mod 256 (8-bit wrap); set busy=1; go to RESP_WAIT.
  - When it returns high with SHORT_MIN<=low_cnt<START_MIN_LOW: pulse short_start and stay in IDLE.
  - low_cnt clears on every rising edge of sync_in.
- RESP_WAIT: release the line for RESP_WAIT cycles; line activity is ignored.
- RESP_LOW: drive 0 for RESP_LOW cycles.
- RESP_HIGH: release for RESP_HIGH cycles.
- BIT_LOW: drive 0 for BIT_LOW cycles.
- BIT_HIGH:
  - Release for HIGH_ONE or HIGH_ZERO cycles according to the current bit.
  - Bit order is MSB first: RH_integral, RH_decimal, T_integral, T_decimal, checksum.
  - A 6-bit bit index counts 0..39.
  - After bit 39, go to END_LOW; otherwise return to BIT_LOW with the index incremented.
- END_LOW: drive 0 for END_LOW cycles, then release.
- GUARD:
  - Lasts 8 cycles with the line released; absorbs synchronizer lag so no false short_start occurs.
  - At GUARD entry, frame_done pulses and busy drops on the same edge.
  - Then go to IDLE.
- During transmission the line is never sampled: a host pulling low mid-frame has no effect.
- Input bytes may change at any time; only the values latched at start acceptance are sent.
- Frame duration with all-zero data: 2100+4000+4000+40×(2500+1400)+2500 = 168600 cycles.

Optional Feature:
- Macro: DHT_EMU_ERR_INJECT_EN.
- Defined: err_inject is sampled at start acceptance; if it is 1, the transmitted checksum is computed checksum XOR 8'h01.
- Undefined: err_inject is ignored (port kept, unused) and the checksum is always correct.

Decomposition:
- Package dht_pkg holds:
  - the state encoding (IDLE, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW, GUARD);
  - default timing constants shared with the reader;
  - FRAME_BITS=40 and the guard length 8.
- One sub-module, dht_in_sync: 2-FF synchronizer with reset value 1.

Test Plan:
- Nominal frame: bench pull-up; host drives low 900000 cycles, then releases. Data 55,0,24,0 → response low starts 2100 cycles after release (+2 sync); frame bytes 0x37,0x00,0x18,0x00,0x4F; one frame_done pulse; busy high throughout the frame.
- Short start: host low 10000 cycles → one short_start pulse, line never driven, busy stays 0.
- Checksum wrap: data FF,FF,01,02 → checksum byte 0x01.
- Mid-frame reset: reset asserted during bit 20 → line is 'z' after one edge, busy=0, no frame_done; the next valid start yields a complete frame.
- Loopback: connect to the existing DHT reader with data 60,5,30,2 → the reader reports the same bytes, checksum 0x61, data_valid pulses.
- Error injection with DHT_EMU_ERR_INJECT_EN: err_inject=1 with data 60,5,30,2 → transmitted checksum 0x60 and the reader flags invalid. Without the macro → checksum 0x61.
